// File: rtl/load_align_unit.sv
// load_align_unit: accepts a load from stage 3, waits for the data-memory
// read word, extracts and extends the addressed byte/halfword/word and hands
// the registered result to writeback. The pipeline is stalled while the
// memory response is outstanding.
//
// Handshake: a load is accepted on a clock edge where state is IDLE,
// issue_valid=1, the opcode is LOAD and kill=0. The response is taken on the
// first edge in WAIT/DRAIN where mem_rvalid=1 (no backpressure toward memory).
// load_valid/load_err are single-cycle pulses; load_data/load_rd hold between
// pulses.
module load_align_unit #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] stage3_inst,
    input  logic [1:0]  shamt,
    input  logic        issue_valid,
    input  logic        kill,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic [4:0]  load_rd,
    output logic        load_err
);

    localparam logic [6:0] OPC_LOAD = 7'b0000011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] counter;
    logic [2:0]       cap_funct3;
    logic [1:0]       cap_shamt;
    logic [4:0]       cap_rd;

    logic             issue_ok;
    logic             cnt_done;
    logic [7:0]       byte_v;
    logic [15:0]      half_v;
    logic [31:0]      ext_data;
    logic             ext_illegal;

    // Only opcode, rd and funct3 of the instruction matter here.
    logic unused_inst;
    assign unused_inst = &{1'b0, stage3_inst[31:15]};

    assign issue_ok = issue_valid && (stage3_inst[6:0] == OPC_LOAD) && !kill;
    // ">=" so a kill taken on the last WAIT cycle still lets DRAIN time out.
    assign cnt_done = (counter >= CNT_W'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; in WAIT a returning response wins over kill and timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (issue_ok) state_nxt = WAIT;
            end
            WAIT: begin
                if (mem_rvalid)    state_nxt = IDLE;
                else if (kill)     state_nxt = DRAIN;
                else if (cnt_done) state_nxt = IDLE;
            end
            DRAIN: begin
                if (mem_rvalid || cnt_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stall output: hold upstream while the response is still missing.
    always_comb begin
        stall = ((state == WAIT) && !mem_rvalid) || (state == DRAIN);
    end

    // Wait counter: cleared while idle, free-running through WAIT and DRAIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter <= '0;
        end else if (state == IDLE) begin
            counter <= '0;
        end else begin
            counter <= counter + 1'b1;
        end
    end

    // Capture funct3/shamt/rd when a load is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_funct3 <= 3'd0;
            cap_shamt  <= 2'd0;
            cap_rd     <= 5'd0;
        end else if (state == IDLE && issue_ok) begin
            cap_funct3 <= stage3_inst[14:12];
            cap_shamt  <= shamt;
            cap_rd     <= stage3_inst[11:7];
        end
    end

    // Lane selection and extension; a halfword at offset 3 uses the upper
    // half, matching the SH store lane mask 1100.
    always_comb begin
        byte_v      = 8'd0;
        half_v      = 16'd0;
        ext_data    = 32'd0;
        ext_illegal = 1'b0;
        case (cap_shamt)
            2'd0:    byte_v = mem_rdata[7:0];
            2'd1:    byte_v = mem_rdata[15:8];
            2'd2:    byte_v = mem_rdata[23:16];
            default: byte_v = mem_rdata[31:24];
        endcase
        case (cap_shamt)
            2'd0:    half_v = mem_rdata[15:0];
            2'd1:    half_v = mem_rdata[23:8];
            default: half_v = mem_rdata[31:16];
        endcase
        case (cap_funct3)
            3'b000:  ext_data = {{24{byte_v[7]}}, byte_v};
            3'b100:  ext_data = {24'd0, byte_v};
            3'b001:  ext_data = {{16{half_v[15]}}, half_v};
            3'b101:  ext_data = {16'd0, half_v};
            3'b010:  ext_data = mem_rdata;
            default: ext_illegal = 1'b1;
        endcase
    end

    // Result registers and the one-cycle valid/error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_valid <= 1'b0;
            load_err   <= 1'b0;
            load_data  <= 32'd0;
            load_rd    <= 5'd0;
        end else begin
            load_valid <= 1'b0;
            load_err   <= 1'b0;
            if (state == WAIT) begin
                if (mem_rvalid) begin
                    load_valid <= 1'b1;
                    load_err   <= ext_illegal;
                    load_data  <= ext_data;
                    load_rd    <= cap_rd;
                end else if (!kill && cnt_done) begin
                    load_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_load_align_unit.sv
// tb_load_align_unit: directed and randomized checks for load_align_unit.
// Completed loads are predicted into exp_q when the response is driven and
// popped by a monitor on the falling edge whenever load_valid is seen.
module tb_load_align_unit;

    localparam int TIMEOUT = 8;

    logic        clk;
    logic        rst;
    logic [31:0] stage3_inst;
    logic [1:0]  shamt;
    logic        issue_valid;
    logic        kill;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        load_valid;
    logic [31:0] load_data;
    logic [4:0]  load_rd;
    logic        load_err;

    int vectors;
    int miscompares;

    // {load_err, load_rd, load_data}
    logic [37:0] exp_q[$];

    load_align_unit #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
        .clk         (clk),
        .rst         (rst),
        .stage3_inst (stage3_inst),
        .shamt       (shamt),
        .issue_valid (issue_valid),
        .kill        (kill),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .stall       (stall),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_rd     (load_rd),
        .load_err    (load_err)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // Reference extraction.
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [1:0] s,
                                          input logic [31:0] w);
        logic [31:0] sh;
        int off;
        off = (s == 2'd3 && f3[1:0] == 2'b01) ? 16 : 8 * int'(s);
        sh  = w >> off;
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b100:  return {24'd0, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b101:  return {16'd0, sh[15:0]};
            3'b010:  return w;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] load_inst(input logic [2:0] f3, input logic [4:0] rd);
        return {17'h1A5A5, f3, rd, 7'b0000011};
    endfunction

    // Monitor: every load_valid must match the oldest prediction.
    always @(negedge clk) begin
        if (!rst && load_valid === 1'b1) begin
            logic [37:0] got;
            logic [37:0] exp;
            got = {load_err, load_rd, load_data};
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_load_valid: got %h, required no completion", got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL load_result: got %h, required %h", got, exp);
                end
            end
        end
    end

    // Driver tasks; callers sit 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] f3, input logic [1:0] s, input logic [4:0] rd);
        stage3_inst = load_inst(f3, rd);
        shamt       = s;
        issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        stage3_inst = 32'd0;
        shamt       = 2'd0;
    endtask

    task automatic respond(input logic [31:0] w, input logic [37:0] exp);
        mem_rvalid = 1'b1;
        mem_rdata  = w;
        exp_q.push_back(exp);
        #1;
        vectors++;
        if (stall !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_on_rvalid: got %b, required 0", stall);
        end
        step();
        mem_rvalid = 1'b0;
        vectors++;
        if (load_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL load_valid_latency: got %b, required 1", load_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; stage3_inst = 32'd0; shamt = 2'd0; issue_valid = 1'b0;
        kill = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        #3;
        vectors++;
        if ({stall, load_valid, load_data, load_rd, load_err} !== 40'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {stall, load_valid, load_data, load_rd, load_err});
        end
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_lb_delay();
        issue(3'b000, 2'd2, 5'd9);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (stall !== 1'b1) begin
                miscompares++;
                $display("FAIL lb_stall cycle %0d: got %b, required 1", i, stall);
            end
            step();
        end
        respond(32'h1280_FF34, {1'b0, 5'd9, 32'hFFFF_FF80});
        step();
        vectors++;
        if (load_valid !== 1'b0 || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL lb_pulse_end: got valid=%b stall=%b, required 0 0", load_valid, stall);
        end
    endtask

    task automatic test_lhu_imm();
        issue(3'b101, 2'd1, 5'd17);
        respond(32'hAB9C_D5EF, {1'b0, 5'd17, 32'h0000_9CD5});
        step();
    endtask

    task automatic test_lh_s3();
        issue(3'b001, 2'd3, 5'd3);
        respond(32'h8001_0000, {1'b0, 5'd3, 32'hFFFF_8001});
        step();
    endtask

    task automatic test_kill_drain();
        issue(3'b010, 2'd0, 5'd12);
        step();
        step();
        kill = 1'b1;
        step();
        kill = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (stall !== 1'b1) begin
                miscompares++;
                $display("FAIL drain_stall cycle %0d: got %b, required 1", i, stall);
            end
            step();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        #1;
        vectors++;
        if (stall !== 1'b1) begin
            miscompares++;
            $display("FAIL drain_stall_rvalid: got %b, required 1", stall);
        end
        step();
        mem_rvalid = 1'b0;
        vectors++;
        if (load_valid !== 1'b0 || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_exit: got valid=%b stall=%b, required 0 0", load_valid, stall);
        end
        issue(3'b010, 2'd1, 5'd13);
        respond(32'h1234_5678, {1'b0, 5'd13, 32'h1234_5678});
        step();
    endtask

    task automatic test_timeout();
        issue(3'b010, 2'd0, 5'd20);
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            vectors++;
            if (stall !== 1'b1 || load_err !== 1'b0) begin
                miscompares++;
                $display("FAIL timeout_wait cycle %0d: got stall=%b err=%b, required 1 0",
                         i, stall, load_err);
            end
            step();
        end
        step();
        vectors++;
        if (load_err !== 1'b1 || stall !== 1'b0 || load_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_err: got err=%b stall=%b valid=%b, required 1 0 0",
                     load_err, stall, load_valid);
        end
        step();
        vectors++;
        if (load_err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_err_end: got %b, required 0", load_err);
        end
    endtask

    task automatic test_illegal();
        issue(3'b011, 2'd1, 5'd21);
        respond(32'hFFFF_FFFF, {1'b1, 5'd21, 32'd0});
        vectors++;
        if (load_err !== 1'b1) begin
            miscompares++;
            $display("FAIL illegal_err: got %b, required 1", load_err);
        end
        step();
    endtask

    task automatic test_ignore();
        stage3_inst = 32'h00A0_0033;
        issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        vectors++;
        if (stall !== 1'b0) begin
            miscompares++;
            $display("FAIL nonload_ignored: got stall=%b, required 0", stall);
        end
        stage3_inst = load_inst(3'b010, 5'd4);
        issue_valid = 1'b1;
        kill        = 1'b1;
        step();
        issue_valid = 1'b0;
        kill        = 1'b0;
        vectors++;
        if (stall !== 1'b0) begin
            miscompares++;
            $display("FAIL killed_issue_ignored: got stall=%b, required 0", stall);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_AAAA;
        step();
        mem_rvalid = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        issue(3'b010, 2'd0, 5'd7);
        step();
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({stall, load_valid, load_data, load_rd, load_err} !== 40'd0) begin
            miscompares++;
            $display("FAIL async_reset: got %h, required 0",
                     {stall, load_valid, load_data, load_rd, load_err});
        end
        step();
        rst = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_F00D;
        step();
        mem_rvalid = 1'b0;
        vectors++;
        if (load_valid !== 1'b0 || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL rvalid_after_reset: got valid=%b stall=%b, required 0 0",
                     load_valid, stall);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [2:0] legal [5];
        legal[0] = 3'b000; legal[1] = 3'b001; legal[2] = 3'b010;
        legal[3] = 3'b100; legal[4] = 3'b101;
        for (int n = 0; n < 24; n++) begin
            logic [2:0]  f3;
            logic [1:0]  s;
            logic [4:0]  rd;
            logic [31:0] w;
            int          dly;
            f3  = legal[$urandom_range(0, 4)];
            s   = 2'($urandom_range(0, 3));
            rd  = 5'($urandom_range(0, 31));
            w   = $urandom();
            dly = $urandom_range(0, 3);
            issue(f3, s, rd);
            for (int d = 0; d < dly; d++) begin
                vectors++;
                if (stall !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_stall load %0d: got %b, required 1", n, stall);
                end
                step();
            end
            respond(w, {1'b0, rd, model(f3, s, w)});
        end
        step();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_lb_delay();
        test_lhu_imm();
        test_lh_s3();
        test_kill_drain();
        test_timeout();
        test_illegal();
        test_ignore();
        test_async_reset();
        test_back_to_back();
        step();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL pending_results: got %0d outstanding, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
